// File: rtl/cordic_request_sequencer.sv
// Request sequencer for the sine/cosine CORDIC unit: queues angle requests
// in a small FIFO, issues them one at a time over the beg/ready/ack
// handshake, and holds each result in a valid/ready output register.
module cordic_request_sequencer #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // request side
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [W-1:0]             req_angle,
    input  logic [1:0]               req_region,
    input  logic                     req_op,
    input  logic [TAG_W-1:0]         req_tag,
    // CORDIC side
    output logic                     beg_fsm_cordic,
    output logic                     ack_cordic,
    output logic                     cordic_op,
    output logic [W-1:0]             cordic_data,
    output logic [1:0]               cordic_region,
    input  logic                     ready_cordic,
    input  logic [W-1:0]             cordic_result,
    input  logic                     cordic_ovf,
    input  logic                     cordic_unf,
    // result side
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [W-1:0]             res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_ovf,
    output logic                     res_unf,
    // status
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = W + 3 + TAG_W;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACK,
        S_CLEAR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic [EW-1:0]    w_head;

    logic             r_beg;
    logic             r_ack;
    logic             r_issue_op;
    logic [W-1:0]     r_issue_data;
    logic [1:0]       r_issue_region;
    logic [TAG_W-1:0] r_issue_tag;

    logic             r_res_valid;
    logic [W-1:0]     r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_ovf;
    logic             r_res_unf;

    // Full FIFO refuses a push even when a pop happens in the same cycle.
    assign req_ready  = (r_count < FULL);
    assign w_push     = req_valid && req_ready;
    assign w_head     = r_mem[r_rptr];
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE);

    assign beg_fsm_cordic = r_beg;
    assign ack_cordic     = r_ack;
    assign cordic_op      = r_issue_op;
    assign cordic_data    = r_issue_data;
    assign cordic_region  = r_issue_region;

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;
    assign res_ovf   = r_res_ovf;
    assign res_unf   = r_res_unf;

    // FIFO storage: write the packed request at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {req_angle, req_region, req_op, req_tag};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, FIFO pop and result capture strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ready_cordic && (!r_res_valid || res_ready)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                // Wait for ready to drop so one result is never captured twice.
                if (!ready_cordic) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Issue registers and one-cycle start/ack pulses toward the CORDIC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beg          <= 1'b0;
            r_ack          <= 1'b0;
            r_issue_op     <= 1'b0;
            r_issue_data   <= '0;
            r_issue_region <= '0;
            r_issue_tag    <= '0;
        end else begin
            r_beg <= w_pop;
            r_ack <= w_capture;
            if (w_pop) begin
                {r_issue_data, r_issue_region, r_issue_op, r_issue_tag} <= w_head;
            end
        end
    end

    // Result register: capture wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_ovf   <= 1'b0;
            r_res_unf   <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= cordic_result;
            r_res_tag   <= r_issue_tag;
            r_res_ovf   <= cordic_ovf;
            r_res_unf   <= cordic_unf;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

endmodule
